// File: rtl/ssd_pkg.sv
// Shared types and constants for the 4-digit seven-segment driver.
// Holds the converter state encoding, segment patterns and the digit decoder.
package ssd_pkg;

  localparam int VALUE_W    = 13;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_W      = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  // Cathode patterns {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Codes above 9 never come out of the converter; they decode to blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/ssd_driver_bin2bcd.sv
// Sequential binary-to-BCD converter using shift-add-3, one value bit per cycle.
// Handshake: a value is taken on a rising edge with valid=1 and ready=1; valid while ready=0 is dropped.
module bin2bcd
  import ssd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               valid,
  output logic               ready,
  output logic [BCD_W-1:0]   bcd,
  output logic               done,
  output conv_state_t        state
);

  localparam logic [3:0] SHIFT_LAST = 4'(VALUE_W - 1);

  conv_state_t        state_q, state_d;
  logic [VALUE_W-1:0] sr_q, sr_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BCD_W-1:0]   adj;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
    end
  end

  // Add 3 to every nibble of 5 or more before the shift doubles it.
  always_comb begin
    adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (work_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      else                          adj[4*i +: 4] = work_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (valid) begin
          sr_d    = value;
          work_d  = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        work_d = (adj << 1) | BCD_W'(sr_q[VALUE_W-1]);
        sr_d   = sr_q << 1;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == SHIFT_LAST) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bcd   = work_q;
  assign state = state_q;

endmodule

// File: rtl/ssd_driver.sv
// Four-digit multiplexed seven-segment driver: converts a 13-bit value to BCD and
// scans the digits, one per REFRESH_DIV clocks, with optional leading-zero blanking.
module ssd_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               valid,
  output logic               ready,
  output logic [3:0]         an,
  output logic [6:0]         seg,
  output logic               dp,
  output conv_state_t        dbg_state
);

  localparam int DIV_CLOG = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DIV_W    = (DIV_CLOG > 17) ? DIV_CLOG : 17;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  logic [BCD_W-1:0] conv_bcd;
  logic             conv_done;

  logic [DIV_W-1:0] div_q;
  logic [1:0]       idx_q;
  logic [BCD_W-1:0] disp_q;

  bin2bcd u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .valid (valid),
    .ready (ready),
    .bcd   (conv_bcd),
    .done  (conv_done),
    .state (dbg_state)
  );

  // Display register loads only on the DONE->IDLE edge; the scan keeps running meanwhile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      idx_q  <= '0;
      disp_q <= '0;
    end else begin
      if (div_q == DIV_LAST) begin
        div_q <= '0;
        idx_q <= idx_q + 2'd1;
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
      if (conv_done) disp_q <= conv_bcd;
    end
  end

  logic [3:0]            digit;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  any_nonzero;

  // A digit above the units blanks when it and every higher digit are zero.
  always_comb begin
    lz_blank    = '0;
    any_nonzero = 1'b0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      any_nonzero = any_nonzero | (disp_q[4*i +: 4] != 4'd0);
      lz_blank[i] = !any_nonzero;
    end
  end

  always_comb begin
    an    = ~(4'b0001 << idx_q);
    digit = disp_q[{idx_q, 2'b00} +: 4];
    if (BLANK_LZ && lz_blank[idx_q]) seg = SEG_BLANK;
    else                             seg = seg_decode(digit);
    dp    = 1'b1;
  end

endmodule
